// File: rtl/move_sequencer_pkg.sv
// Shared cube move encodings and sequencer state enum for move_sequencer.
// MOVE_SEQ_TIMEOUT_EN adds the sticky FAULT state.
package cube_pkg;

   localparam int FACE_W    = 3;
   localparam int TURN_W    = 2;
   localparam int MOVE_W    = FACE_W + TURN_W;
   localparam int NUM_FACES = 6;

   typedef enum logic [FACE_W-1:0] {
      FACE_U = 3'd0,
      FACE_D = 3'd1,
      FACE_F = 3'd2,
      FACE_B = 3'd3,
      FACE_L = 3'd4,
      FACE_R = 3'd5
   } face_e;

   typedef enum logic [TURN_W-1:0] {
      TURN_CW   = 2'd0,
      TURN_CCW  = 2'd1,
      TURN_HALF = 2'd2
   } turn_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TURN_WAIT,
      ST_SETTLE_WAIT
`ifdef MOVE_SEQ_TIMEOUT_EN
      , ST_FAULT
`endif
   } seq_state_e;

   function automatic logic move_is_legal(input logic [MOVE_W-1:0] m);
      return (m[MOVE_W-1:TURN_W] < FACE_W'(NUM_FACES)) && (m[TURN_W-1:0] != 2'd3);
   endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Move command channel between the solver (master) and move_sequencer (slave).
interface move_sequencer_if;
   logic       move_valid;
   logic       move_ready;
   logic [4:0] move_data;

   modport master (output move_valid, output move_data, input  move_ready);
   modport slave  (input  move_valid, input  move_data, output move_ready);
endinterface

// File: rtl/move_sequencer_move_fifo.sv
// Count-based synchronous move FIFO; clr empties it on the next edge.
module move_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/move_sequencer.sv
// Queues cube moves and plays them one at a time through a turn/settle timer handshake.
// Define MOVE_SEQ_TIMEOUT_EN to add the per-phase watchdog and sticky FAULT state.
//
// state          | meaning
// IDLE           | nothing in service, waiting for a queued move
// LOAD           | pop FIFO head, latch face/turn
// TURN_WAIT      | servo driven, waiting for turn delay
// SETTLE_WAIT    | servo released, waiting for settle delay
// FAULT          | watchdog expired (optional), held until reset/flush
module move_sequencer
   import cube_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic               clock,
   input  logic               reset,
   move_sequencer_if.slave    mv,
   input  logic               flush,
   output logic               timer_start,
   input  logic               timer_done,
   output logic               servo_en,
   output logic [FACE_W-1:0]  servo_face,
   output logic [TURN_W-1:0]  servo_turn,
   output logic               busy,
   output logic               seq_done,
   output logic               illegal_move,
   output logic [7:0]         move_count,
   output logic               fault
);
   seq_state_e         state_q, state_d;
   logic               first_q, first_d;
   logic [7:0]         move_count_q, move_count_d;
   logic               seq_done_q, seq_done_d;
   logic               illegal_q, illegal_d;
   logic [FACE_W-1:0]  face_q, face_d;
   logic [TURN_W-1:0]  turn_q, turn_d;
   logic [MOVE_W-1:0]  fifo_head;
   logic               fifo_full, fifo_empty;
   logic               accept, legal, push, pop, wait_phase, done_eff, settle_done;
   logic               wd_hit;

   assign accept      = mv.move_valid && mv.move_ready;
   assign legal       = move_is_legal(mv.move_data);
   assign push        = accept && legal && !flush;
   assign pop         = (state_q == ST_LOAD) && !flush;
   assign wait_phase  = (state_q == ST_TURN_WAIT) || (state_q == ST_SETTLE_WAIT);
   // A done arriving with the start pulse belongs to the previous timer run.
   assign done_eff    = timer_done && wait_phase && !first_q;
   assign settle_done = (state_q == ST_SETTLE_WAIT) && done_eff && !flush;

   move_fifo #(.DEPTH(DEPTH), .W(MOVE_W)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .clr     (flush),
      .push    (push),
      .pop     (pop),
      .wr_data (mv.move_data),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef MOVE_SEQ_TIMEOUT_EN
   logic [26:0] wd_q, wd_d;
   assign wd_hit = wait_phase && (wd_q == 27'(TIMEOUT_CYCLES - 1));
   always_comb begin
      wd_d = wd_q;
      if (first_d)         wd_d = '0;
      else if (wait_phase) wd_d = wd_q + 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`else
   logic unused_timeout;
   assign wd_hit         = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:        if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:        state_d = ST_TURN_WAIT;
            ST_TURN_WAIT: begin
               if (done_eff)    state_d = ST_SETTLE_WAIT;
`ifdef MOVE_SEQ_TIMEOUT_EN
               else if (wd_hit) state_d = ST_FAULT;
`endif
            end
            ST_SETTLE_WAIT: begin
               if (done_eff)    state_d = fifo_empty ? ST_IDLE : ST_LOAD;
`ifdef MOVE_SEQ_TIMEOUT_EN
               else if (wd_hit) state_d = ST_FAULT;
`endif
            end
`ifdef MOVE_SEQ_TIMEOUT_EN
            ST_FAULT:       state_d = ST_FAULT;
`endif
            default:        state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      servo_en      = (state_q == ST_TURN_WAIT);
      timer_start   = wait_phase && first_q;
      busy          = !fifo_empty || (state_q != ST_IDLE);
      mv.move_ready = !fifo_full;
      seq_done      = seq_done_q;
      illegal_move  = illegal_q;
      move_count    = move_count_q;
      servo_face    = face_q;
      servo_turn    = turn_q;
`ifdef MOVE_SEQ_TIMEOUT_EN
      fault         = (state_q == ST_FAULT);
`else
      fault         = 1'b0;
`endif
   end

   always_comb begin
      first_d      = (state_d == ST_TURN_WAIT || state_d == ST_SETTLE_WAIT) && (state_d != state_q);
      move_count_d = move_count_q + 8'(settle_done);
      seq_done_d   = settle_done && fifo_empty;
      illegal_d    = accept && !legal;
      face_d       = face_q;
      turn_d       = turn_q;
      if (pop) begin
         face_d = fifo_head[MOVE_W-1:TURN_W];
         turn_d = fifo_head[TURN_W-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         first_q      <= 1'b0;
         move_count_q <= '0;
         seq_done_q   <= 1'b0;
         illegal_q    <= 1'b0;
         face_q       <= '0;
         turn_q       <= '0;
      end else begin
         first_q      <= first_d;
         move_count_q <= move_count_d;
         seq_done_q   <= seq_done_d;
         illegal_q    <= illegal_d;
         face_q       <= face_d;
         turn_q       <= turn_d;
      end
   end

endmodule
